// File: rtl/score_keeper_pkg.sv
// Shared game definitions: FSM state encoding, default tuning values and the
// score width agreed with the digit renderer.
package score_keeper_pkg;

  localparam int unsigned ScoreW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StWin,
    StOver
  } game_state_e;

  localparam logic [ScoreW-1:0] MaxScoreDef   = 8'd15;
  localparam logic [1:0]        StartLivesDef = 2'd3;
  localparam logic [9:0]        FrameLineDef  = 10'd480;

endpackage

// File: rtl/score_keeper_rise_detect.sv
// One-bit rising-edge detector: the pulse is high in the cycle the input
// first reads high, compared against a registered copy of the previous level.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_pulse
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_armed <= 1'b1;
    end
  end

  // Blind for one cycle after reset so a level held through release is not an edge.
  assign o_pulse = i_d & ~r_prev & r_armed;

endmodule

// File: rtl/score_keeper.sv
// Game score/lives keeper: hits accumulate as pending and commit to the
// displayed score only at the first blanking line, so a frame never tears.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter logic [ScoreW-1:0] MAX_SCORE   = MaxScoreDef,
  parameter logic [1:0]        START_LIVES = StartLivesDef,
  parameter logic [9:0]        FRAME_LINE  = FrameLineDef
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_hit,
  input  logic              i_miss,
  input  logic [9:0]        i_v_coord,
  output logic [ScoreW-1:0] o_score,
  output logic [1:0]        o_lives,
  output logic              o_playing,
  output logic              o_game_over,
  output logic              o_win
);

  logic w_start_rise;
  logic w_hit_rise;
  logic w_miss_rise;

  rise_detect u_start_rise (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_start), .o_pulse(w_start_rise));
  rise_detect u_hit_rise   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_hit),   .o_pulse(w_hit_rise));
  rise_detect u_miss_rise  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_miss),  .o_pulse(w_miss_rise));

  game_state_e       r_state;
  logic [ScoreW-1:0] r_score;
  logic [1:0]        r_lives;
  logic [2:0]        r_pending;
  logic [9:0]        r_vprev;
  logic              r_playing;
  logic              r_game_over;
  logic              r_win;

  logic              w_boundary;
  logic [ScoreW:0]   w_commit;
  logic              w_reach_max;
  logic [ScoreW-1:0] w_commit_score;
  logic              w_lose;

  assign w_boundary     = (i_v_coord == FRAME_LINE) && (r_vprev != FRAME_LINE);
  assign w_commit       = {1'b0, r_score} + {6'd0, r_pending} + {8'd0, w_hit_rise};
  assign w_reach_max    = w_commit >= {1'b0, MAX_SCORE};
  assign w_commit_score = w_reach_max ? MAX_SCORE : w_commit[ScoreW-1:0];
  assign w_lose         = w_miss_rise && (r_lives == 2'd1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_score     <= '0;
      r_lives     <= '0;
      r_pending   <= '0;
      r_vprev     <= '0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_vprev <= i_v_coord;
      unique case (r_state)
        StIdle, StWin, StOver: begin
          if (w_start_rise) begin
            r_state     <= StPlay;
            r_score     <= '0;
            r_lives     <= START_LIVES;
            r_pending   <= '0;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
          end
        end
        StPlay: begin
          if (w_boundary) begin
            r_score   <= w_commit_score;
            r_pending <= '0;
          end else if (w_hit_rise && (r_pending != 3'd7)) begin
            r_pending <= r_pending + 3'd1;
          end
          if (w_miss_rise && (r_lives != 2'd0)) begin
            r_lives <= r_lives - 2'd1;
          end
          // Losing the last life outranks a win committed in the same cycle.
          if (w_lose) begin
            r_state     <= StOver;
            r_pending   <= '0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b1;
          end else if (w_boundary && w_reach_max) begin
            r_state   <= StWin;
            r_pending <= '0;
            r_playing <= 1'b0;
            r_win     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_playing   = r_playing;
  assign o_game_over = r_game_over;
  assign o_win       = r_win;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: expected outputs are queued as each step is
// driven and popped/compared once the step's clock edge has taken effect.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       hit;
  logic       miss;
  logic [9:0] v_coord;
  logic [7:0] score;
  logic [1:0] lives;
  logic       playing;
  logic       game_over;
  logic       win;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [12:0] val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  score_keeper dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_hit      (hit),
    .i_miss     (miss),
    .i_v_coord  (v_coord),
    .o_score    (score),
    .o_lives    (lives),
    .o_playing  (playing),
    .o_game_over(game_over),
    .o_win      (win)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic [1:0] l,
                            input logic p, input logic o, input logic w);
    exp_t e;
    e.tag = tag;
    e.val = {s, l, p, o, w};
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [12:0] act;
    act = {score, lives, playing, game_over, win};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard-empty observed=%h required=entry", act);
    end else begin
      e = exp_q.pop_front();
      assert (act === e.val)
      else begin
        bad++;
        $error("FAIL %s observed score=%0d lives=%0d p/o/w=%b required score=%0d lives=%0d p/o/w=%b",
               e.tag, act[12:5], act[4:3], act[2:0], e.val[12:5], e.val[4:3], e.val[2:0]);
      end
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Steps to the commit line; leaves V on the boundary for the caller's check.
  task automatic to_boundary();
    v_coord = 10'd479;
    tick();
    v_coord = 10'd480;
    tick();
  endtask

  task automatic leave_boundary();
    v_coord = 10'd0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0; v_coord = 10'd0;
    tick(); tick();
    expect_out("reset", 8'd0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();
    rst_n = 1'b1;
    tick(); tick();

    // Start, three hits inside one frame, commit at line 480.
    start = 1'b1; tick();
    expect_out("start", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    start = 1'b0; tick();
    pulse_hit(); pulse_hit(); pulse_hit();
    expect_out("pre_commit", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    v_coord = 10'd479; tick();
    expect_out("line479", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    v_coord = 10'd480; tick();
    expect_out("commit3", 8'd3, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    tick();
    expect_out("hold480", 8'd3, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    leave_boundary();

    // Held hit counts once.
    hit = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    hit = 1'b0; tick();
    expect_out("held_hit_nocommit", 8'd3, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    to_boundary();
    expect_out("held_hit_commit", 8'd4, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    leave_boundary();

    // Hit edge landing on the boundary cycle with pending=2.
    pulse_hit(); pulse_hit();
    v_coord = 10'd479; tick();
    v_coord = 10'd480; hit = 1'b1; tick();
    expect_out("hit_on_boundary", 8'd7, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    hit = 1'b0; leave_boundary();
    to_boundary();
    expect_out("pending_cleared", 8'd7, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    leave_boundary();

    // Start edge during play is ignored.
    pulse_hit(); pulse_start();
    to_boundary();
    expect_out("start_in_play", 8'd8, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    leave_boundary();

    // Reach 13, then 4 more hits saturate at 15 and win.
    for (int i = 0; i < 5; i++) pulse_hit();
    to_boundary();
    expect_out("score13", 8'd13, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    leave_boundary();
    for (int i = 0; i < 4; i++) pulse_hit();
    to_boundary();
    expect_out("win_sat", 8'd15, 2'd3, 1'b0, 1'b0, 1'b1); check_out();
    leave_boundary();
    pulse_hit(); pulse_hit();
    miss = 1'b1; tick(); miss = 1'b0; tick();
    to_boundary();
    expect_out("win_ignores", 8'd15, 2'd3, 1'b0, 1'b0, 1'b1); check_out();
    leave_boundary();
    start = 1'b1; tick();
    expect_out("restart_from_win", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    start = 1'b0; tick();

    // Three misses run lives down to game over; score stays.
    pulse_hit(); to_boundary(); leave_boundary();
    miss = 1'b1; tick();
    expect_out("miss1", 8'd1, 2'd2, 1'b1, 1'b0, 1'b0); check_out();
    miss = 1'b0; tick();
    miss = 1'b1; tick();
    expect_out("miss2", 8'd1, 2'd1, 1'b1, 1'b0, 1'b0); check_out();
    miss = 1'b0; tick();
    miss = 1'b1; tick();
    expect_out("miss3_over", 8'd1, 2'd0, 1'b0, 1'b1, 1'b0); check_out();
    miss = 1'b0; tick();
    pulse_hit(); to_boundary();
    expect_out("over_ignores", 8'd1, 2'd0, 1'b0, 1'b1, 1'b0); check_out();
    leave_boundary();

    // Pending saturates at 7; last-life miss beats a same-cycle win.
    pulse_start();
    miss = 1'b1; tick(); miss = 1'b0; tick();
    miss = 1'b1; tick(); miss = 1'b0; tick();
    for (int i = 0; i < 9; i++) pulse_hit();
    to_boundary();
    expect_out("pending_sat7", 8'd7, 2'd1, 1'b1, 1'b0, 1'b0); check_out();
    leave_boundary();
    for (int i = 0; i < 7; i++) pulse_hit();
    v_coord = 10'd479; tick();
    v_coord = 10'd480; hit = 1'b1; miss = 1'b1; tick();
    expect_out("over_beats_win", 8'd15, 2'd0, 1'b0, 1'b1, 1'b0); check_out();
    hit = 1'b0; miss = 1'b0; leave_boundary();

    // Reset mid-play abandons pending hits; held start is not an edge.
    pulse_start();
    for (int i = 0; i < 4; i++) pulse_hit();
    expect_out("pre_reset", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    rst_n = 1'b0; start = 1'b1; tick();
    expect_out("mid_reset", 8'd0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();
    rst_n = 1'b1; tick(); tick();
    expect_out("held_start", 8'd0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();
    to_boundary();
    expect_out("no_commit_after_rst", 8'd0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();
    leave_boundary();
    start = 1'b0; tick();
    start = 1'b1; tick();
    expect_out("start_after_rst", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0); check_out();
    start = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_SCORE, default 8'd15, sets the saturation/win score (the downstream digit renderer draws 0..15).
REQ-002 Parameter START_LIVES, default 2'd3, sets the lives loaded on game start.
REQ-003 Parameter FRAME_LINE, default 10'd480, sets the V_Coord line at which pending hits commit (first blanking line).
REQ-004 clk  input  1  sole clock, pixel clock shared with the renderer.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 start  input  1  level; its rising edge starts or restarts a game.
REQ-007 hit  input  1  level from collision logic, may stay high many cycles; its rising edge scores one point.
REQ-008 miss  input  1  level; its rising edge costs one life.
REQ-009 V_Coord  input  10  current VGA line, used only for frame-boundary detection.
REQ-010 score  output  8  registered committed score, 0..MAX_SCORE, fed to the renderer.
REQ-011 lives  output  2  registered remaining lives.
REQ-012 playing / game_over / win  output  1 each  registered one-hot state flags; all low in IDLE.

Function
REQ-013 Rising edges on start, hit and miss SHALL be detected against a one-cycle-delayed copy; a held level SHALL count once.
REQ-014 The FSM SHALL have four states: IDLE, PLAY, WIN and OVER.
REQ-015 start edge in IDLE, WIN or OVER -> PLAY next cycle with score=0, lives=START_LIVES and pending=0.
REQ-016 start edge while in PLAY SHALL have no effect.
REQ-017 In PLAY, each hit edge SHALL increment a 3-bit pending counter that saturates at 7; hit and miss edges outside PLAY SHALL be ignored.
REQ-018 Frame boundary = cycle where V_Coord==FRAME_LINE and the previous V_Coord!=FRAME_LINE.
REQ-019 At a boundary in PLAY, the commit SHALL add pending plus any same-cycle hit edge to score, and pending SHALL clear; score SHALL be visible the next cycle.
REQ-020 Commit arithmetic SHALL be 9-bit; if the result is >= MAX_SCORE, score=MAX_SCORE and the next state is WIN.
REQ-021 score SHALL change only at a commit or a start, so a frame is never redrawn mid-scan.
REQ-022 In PLAY, a miss edge SHALL decrement lives immediately; if lives was 1, lives=0 and the next state is OVER.
REQ-023 Miss-to-zero lives takes priority over a same-cycle win commit: state -> OVER with score committed (saturated).
REQ-024 Simultaneous hit and miss edges SHALL both be processed.
REQ-025 Entering WIN or OVER SHALL discard pending hits; score and lives hold until the next start edge.
REQ-026 Output flags SHALL reflect the state register with zero added latency.

Reset
REQ-027 While rst_n is low at a clk edge, all of the following SHALL reset:
- state=IDLE
- score=0, lives=0, pending=0
- all edge-detect history=0
- playing=game_over=win=0
REQ-028 Reset mid-game SHALL abandon the game without commit; a start held high through reset release SHALL NOT count as an edge.

Structure
REQ-029 A shared game package SHALL hold the state enum, MAX_SCORE, START_LIVES and FRAME_LINE defaults, and the 8-bit score width shared with the renderer.
REQ-030 A single sub-module, rise_detect (1-bit registered rising-edge pulse, synchronous active-low reset), SHALL be instantiated three times; the FSM and counters SHALL stay flat.

Verification
REQ-031 Reset, start pulse, 3 hit pulses within one frame, V_Coord stepped to 480 -> score 0 until the commit cycle, then 3; playing=1.
REQ-032 hit held high for 1000 cycles -> pending=1; score +1 at the next boundary.
REQ-033 score=13, 4 hits, boundary -> score=15, win=1, playing=0; further hits ignored; start -> score=0, lives=3.
REQ-034 3 miss edges -> lives 2,1,0 on successive edges; game_over=1 after the third; score unchanged.
REQ-035 hit edge on the exact boundary cycle with pending=2 -> score +3, pending=0.
REQ-036 rst_n low mid-PLAY with pending=4 -> all outputs 0, state IDLE; the next boundary does not change score.
